// File: rtl/axi_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_arbiter_pkg
// Brief    : FSM encoding, AXI constants and requester ids shared by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axi_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4
  } state_e;

  localparam int         AXI_ID_W       = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  localparam logic ID_IF = 1'b0;
  localparam logic ID_DM = 1'b1;

  // AXI size code for a full-width beat of the given byte count
  function automatic logic [2:0] axi_size_f(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_arbiter
// Brief    : Single-beat AXI4 master shared by instruction fetch and data port.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_rdata_o,
  output logic                  if_done_o,
  input  logic                  dm_rd_req_i,
  input  logic                  dm_wr_req_i,
  input  logic [ADDR_W-1:0]     dm_addr_i,
  input  logic [DATA_W-1:0]     dm_wdata_i,
  input  logic [DATA_W/8-1:0]   dm_wstrb_i,
  output logic [DATA_W-1:0]     dm_rdata_o,
  output logic                  dm_done_o,
  output logic                  stall_if_o,
  output logic                  stall_load_o,
  output logic                  stall_store_o,
  output logic [AXI_ID_W-1:0]   awid_o,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [AXI_ID_W-1:0]   bid_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [AXI_ID_W-1:0]   arid_o,
  output logic [ADDR_W-1:0]     araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [AXI_ID_W-1:0]   rid_i,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  localparam int              STRB_W     = DATA_W / 8;
  localparam int              SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [2:0]      AXI_SIZE   = axi_size_f(STRB_W);

  state_e              state_q,    state_d;
  logic                req_id_q,   req_id_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [STRB_W-1:0]   wstrb_q,    wstrb_d;
  logic [SC_W-1:0]     starve_q,   starve_d;
  logic                aw_ok_q,    aw_ok_d;
  logic                w_ok_q,     w_ok_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_done_q,  if_done_d;
  logic                dm_done_q,  dm_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_id_q   <= ID_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      starve_q   <= '0;
      aw_ok_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_id_q   <= req_id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      starve_q   <= starve_d;
      aw_ok_q    <= aw_ok_d;
      w_ok_q     <= w_ok_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_id_d   = req_id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    starve_d   = starve_q;
    aw_ok_d    = aw_ok_q;
    w_ok_d     = w_ok_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // No grant while a done pulse is out: the finished requester still shows its old req.
        if (!if_done_q && !dm_done_q) begin
          if (if_req_i && (starve_q == STARVE_LIM)) begin
            req_id_d = ID_IF;
            addr_d   = if_addr_i;
            starve_d = '0;
            state_d  = S_AR;
          end else if (dm_wr_req_i || dm_rd_req_i) begin
            req_id_d = ID_DM;
            addr_d   = dm_addr_i;
            if (if_req_i && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + SC_W'(1);
            end
            if (dm_wr_req_i) begin
              wdata_d = dm_wdata_i;
              wstrb_d = dm_wstrb_i;
              aw_ok_d = 1'b0;
              w_ok_d  = 1'b0;
              state_d = S_WR;
            end else begin
              state_d = S_AR;
            end
          end else if (if_req_i) begin
            req_id_d = ID_IF;
            addr_d   = if_addr_i;
            starve_d = '0;
            state_d  = S_AR;
          end
        end
      end
      S_AR: begin
        if (arready_i) state_d = S_R;
      end
      S_R: begin
        if (rvalid_i) begin
          if (req_id_q == ID_IF) begin
            if_rdata_d = rdata_i;
            if_done_d  = 1'b1;
          end else begin
            dm_rdata_d = rdata_i;
            dm_done_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        aw_ok_d = aw_ok_q | awready_i;
        w_ok_d  = w_ok_q  | wready_i;
        if ((aw_ok_q | awready_i) && (w_ok_q | wready_i)) state_d = S_B;
      end
      S_B: begin
        if (bvalid_i) begin
          dm_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign if_rdata_o    = if_rdata_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign if_done_o     = if_done_q;
  assign dm_done_o     = dm_done_q;
  assign stall_if_o    = if_req_i    & ~if_done_q;
  assign stall_load_o  = dm_rd_req_i & ~dm_done_q;
  assign stall_store_o = dm_wr_req_i & ~dm_done_q;

  assign arid_o    = {{(AXI_ID_W-1){1'b0}}, req_id_q};
  assign araddr_o  = addr_q;
  assign arlen_o   = AXI_LEN_SINGLE;
  assign arsize_o  = AXI_SIZE;
  assign arburst_o = AXI_BURST_INCR;
  assign arvalid_o = (state_q == S_AR);
  assign rready_o  = (state_q == S_R);

  assign awid_o    = {{(AXI_ID_W-1){1'b0}}, ID_DM};
  assign awaddr_o  = addr_q;
  assign awlen_o   = AXI_LEN_SINGLE;
  assign awsize_o  = AXI_SIZE;
  assign awburst_o = AXI_BURST_INCR;
  assign awvalid_o = (state_q == S_WR) & ~aw_ok_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = (state_q == S_WR) & ~w_ok_q;
  assign bready_o  = (state_q == S_B);

  // Response ids/codes carry no information for this single-outstanding master.
  logic unused_resp;
  assign unused_resp = ^{bid_i, bresp_i, rid_i, rresp_i, rlast_i};

endmodule
`default_nettype wire
